// File: rtl/ps2_mouse_if.sv
// PS/2 mouse receiver bundle: pin inputs plus decoded mouse state.
// Carries the optional Wheel field when MOUSE_WHEEL_EN is defined.
interface ps2_mouse_if #(
  parameter int MAG_W = 8
);
  logic             M_CLK;
  logic             M_Dat;
  logic             Click;
  logic             BtnR;
  logic             BtnM;
  logic             Izquierda;
  logic             Derecha;
  logic             Arriba;
  logic             Abajo;
  logic [MAG_W-1:0] MagX;
  logic [MAG_W-1:0] MagY;
  logic             PktValid;
  logic             ErrPulse;
`ifdef MOUSE_WHEEL_EN
  logic [3:0]       Wheel;
`endif

  modport slave (
`ifdef MOUSE_WHEEL_EN
    output Wheel,
`endif
    input  M_CLK, M_Dat,
    output Click, BtnR, BtnM, Izquierda, Derecha, Arriba, Abajo,
    output MagX, MagY, PktValid, ErrPulse
  );

  modport master (
`ifdef MOUSE_WHEEL_EN
    input  Wheel,
`endif
    output M_CLK, M_Dat,
    input  Click, BtnR, BtnM, Izquierda, Derecha, Arriba, Abajo,
    input  MagX, MagY, PktValid, ErrPulse
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver: filters the pins, deframes 11-bit frames, checks parity,
// assembles 3-byte packets (4 with MOUSE_WHEEL_EN) and decodes buttons/direction/magnitude.
module ps2_mouse_rx #(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int MAG_W       = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  ps2_mouse_if.slave bus
);
`ifdef MOUSE_WHEEL_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam int PW = 8 * (NBYTES - 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          sclk_q, sclk_d, sdat_q, sdat_d;
  logic [FILT_LEN-1:0] hclk_q, hclk_d, hdat_q, hdat_d;
  logic                fclk_q, fclk_d, fdat_q, fdat_d;
  logic [1:0]          idx_q, idx_d;
  logic [2:0]          bcnt_q, bcnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [7:0]          sh_q, sh_d;
  logic                par_q, par_d, pok_q, pok_d;
  logic [6:0]          b0_q, b0_d;
  logic [PW-1:0]       pkt_q, pkt_d;
  logic [2:0]          btn_q, btn_d;
  logic [3:0]          dir_q, dir_d;
  logic [MAG_W-1:0]    magx_q, magx_d, magy_q, magy_d;
  logic                pv_q, pv_d, err_q, err_d;
`ifdef MOUSE_WHEEL_EN
  logic [3:0]          wheel_q, wheel_d;
`endif
  logic                fall, busy, timeout;
  logic signed [8:0]   x_v, y_v;

  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [8:0] v, input logic ovf);
    int m;
    m = (v < 0) ? -int'(v) : int'(v);
    if (ovf || m > (2**MAG_W - 1)) return {MAG_W{1'b1}};
    return MAG_W'(m);
  endfunction

  always_comb begin
    sclk_d  = {sclk_q[0], bus.M_CLK};
    sdat_d  = {sdat_q[0], bus.M_Dat};
    hclk_d  = FILT_LEN'({hclk_q, sclk_q[1]});
    hdat_d  = FILT_LEN'({hdat_q, sdat_q[1]});
    fclk_d  = (&hclk_d) ? 1'b1 : ((|hclk_d) ? fclk_q : 1'b0);
    fdat_d  = (&hdat_d) ? 1'b1 : ((|hdat_d) ? fdat_q : 1'b0);
    fall    = fclk_q & ~fclk_d;
    busy    = (state_q != IDLE) || (idx_q != 2'd0);
    timeout = !fall && busy && (tmo_q == TW'(TIMEOUT_CYC - 1));

    // Last byte of the packet is still in the shift register when the stop bit lands.
    x_v = {b0_q[3], pkt_q[7:0]};
`ifdef MOUSE_WHEEL_EN
    y_v = {b0_q[4], pkt_q[15:8]};
`else
    y_v = {b0_q[4], sh_q};
`endif

    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pok_d   = pok_q;
    b0_d    = b0_q;
    pkt_d   = pkt_q;
    btn_d   = btn_q;
    dir_d   = dir_q;
    magx_d  = magx_q;
    magy_d  = magy_q;
`ifdef MOUSE_WHEEL_EN
    wheel_d = wheel_q;
`endif
    pv_d    = 1'b0;
    err_d   = 1'b0;

    if (fall || !busy) tmo_d = '0;
    else               tmo_d = tmo_q + TW'(1);

    if (timeout) begin
      err_d   = 1'b1;
      state_d = IDLE;
      idx_d   = 2'd0;
      tmo_d   = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!fdat_q) begin
            state_d = DATA;
            bcnt_d  = 3'd0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          sh_d   = {fdat_q, sh_q[7:1]};
          par_d  = par_q ^ fdat_q;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          pok_d   = par_q ^ fdat_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!fdat_q) begin
            err_d = 1'b1;
          end else if (!pok_q) begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end else if (idx_q == 2'd0) begin
            // Byte 0 always carries bit3=1; anything else means we are out of step.
            if (!sh_q[3]) err_d = 1'b1;
            else begin
              b0_d  = {sh_q[7:4], sh_q[2:0]};
              idx_d = 2'd1;
            end
          end else if (idx_q == 2'(NBYTES - 1)) begin
            idx_d  = 2'd0;
            pv_d   = 1'b1;
            btn_d  = b0_q[2:0];
            dir_d  = {x_v[8], !x_v[8] && (x_v != 9'sd0), !y_v[8] && (y_v != 9'sd0), y_v[8]};
            magx_d = sat_mag(x_v, b0_q[5]);
            magy_d = sat_mag(y_v, b0_q[6]);
`ifdef MOUSE_WHEEL_EN
            wheel_d = sh_q[3:0];
`endif
          end else begin
            pkt_d = PW'({sh_q, pkt_q} >> 8);
            idx_d = idx_q + 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      bcnt_q  <= 3'd0;
      tmo_q   <= '0;
      sclk_q  <= '1;
      sdat_q  <= '1;
      hclk_q  <= '1;
      hdat_q  <= '1;
      fclk_q  <= 1'b1;
      fdat_q  <= 1'b1;
      btn_q   <= '0;
      dir_q   <= '0;
      magx_q  <= '0;
      magy_q  <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef MOUSE_WHEEL_EN
      wheel_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      hclk_q  <= hclk_d;
      hdat_q  <= hdat_d;
      fclk_q  <= fclk_d;
      fdat_q  <= fdat_d;
      btn_q   <= btn_d;
      dir_q   <= dir_d;
      magx_q  <= magx_d;
      magy_q  <= magy_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
`ifdef MOUSE_WHEEL_EN
      wheel_q <= wheel_d;
`endif
    end
  end

  // Byte assembly registers are only meaningful under control of the FSM above.
  always_ff @(posedge Clk) begin
    sh_q  <= sh_d;
    par_q <= par_d;
    pok_q <= pok_d;
    b0_q  <= b0_d;
    pkt_q <= pkt_d;
  end

  assign bus.Click     = btn_q[0];
  assign bus.BtnR      = btn_q[1];
  assign bus.BtnM      = btn_q[2];
  assign bus.Izquierda = dir_q[3];
  assign bus.Derecha   = dir_q[2];
  assign bus.Arriba    = dir_q[1];
  assign bus.Abajo     = dir_q[0];
  assign bus.MagX      = magx_q;
  assign bus.MagY      = magy_q;
  assign bus.PktValid  = pv_q;
  assign bus.ErrPulse  = err_q;
`ifdef MOUSE_WHEEL_EN
  assign bus.Wheel     = wheel_q;
`endif
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: bit-bangs PS/2 frames and compares decoded state against
// an arithmetic packet model; short TIMEOUT_CYC keeps the run brief.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;
  localparam int FILT_LEN    = 4;
  localparam int TIMEOUT_CYC = 3000;
  localparam int MAG_W       = 8;
  localparam int HALF        = 15;
`ifdef MOUSE_WHEEL_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  typedef struct packed {
    logic click, btn_r, btn_m, izq, der, arr, aba;
    logic [MAG_W-1:0] mag_x, mag_y;
    logic [3:0] wheel;
  } out_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pv_cnt = 0;
  int   err_cnt = 0;
  out_t cur_exp;

  ps2_mouse_if #(.MAG_W(MAG_W)) bus ();

  ps2_mouse_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .MAG_W(MAG_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (bus.PktValid === 1'b1) pv_cnt++;
    if (bus.ErrPulse === 1'b1) err_cnt++;
  end

  function automatic out_t get_out();
    out_t o;
    o.click = bus.Click;
    o.btn_r = bus.BtnR;
    o.btn_m = bus.BtnM;
    o.izq   = bus.Izquierda;
    o.der   = bus.Derecha;
    o.arr   = bus.Arriba;
    o.aba   = bus.Abajo;
    o.mag_x = bus.MagX;
    o.mag_y = bus.MagY;
`ifdef MOUSE_WHEEL_EN
    o.wheel = bus.Wheel;
`else
    o.wheel = 4'h0;
`endif
    return o;
  endfunction

  // Packet meaning computed from the byte layout with ordinary integer arithmetic.
  function automatic out_t model(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3);
    out_t o;
    int x, y, mx, my, lim;
    lim = (1 << MAG_W) - 1;
    x = b0[4] ? int'(b1) - 256 : int'(b1);
    y = b0[5] ? int'(b2) - 256 : int'(b2);
    mx = (x < 0) ? -x : x;
    my = (y < 0) ? -y : y;
    if (b0[6] || mx > lim) mx = lim;
    if (b0[7] || my > lim) my = lim;
    o.click = b0[0];
    o.btn_r = b0[1];
    o.btn_m = b0[2];
    o.izq   = (x < 0);
    o.der   = (x > 0);
    o.arr   = (y > 0);
    o.aba   = (y < 0);
    o.mag_x = MAG_W'(mx);
    o.mag_y = MAG_W'(my);
    o.wheel = (NB == 4) ? b3[3:0] : 4'h0;
    return o;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.M_Dat = f[i];
      repeat (HALF) @(negedge Clk);
      bus.M_CLK = 1'b0;
      repeat (HALF) @(negedge Clk);
      bus.M_CLK = 1'b1;
    end
    bus.M_Dat = 1'b1;
    repeat (HALF) @(negedge Clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    send_frame(b0, 1'b0, 1'b0, 11);
    send_frame(b1, 1'b0, 1'b0, 11);
    send_frame(b2, 1'b0, 1'b0, 11);
    if (NB == 4) send_frame(b3, 1'b0, 1'b0, 11);
  endtask

  task automatic test_reset();
    out_t got;
    Rst = 1'b1;
    repeat (4) @(negedge Clk);
    Rst = 1'b0;
    repeat (1000) @(negedge Clk);
    got = get_out();
    cur_exp = '0;
    checks++;
    if (got !== cur_exp) begin
      errors++; $display("FAIL reset_outputs got=%h exp=%h", got, cur_exp);
    end
    checks++;
    if (pv_cnt !== 0) begin
      errors++; $display("FAIL reset_pktvalid got=%0d exp=0", pv_cnt);
    end
    checks++;
    if (err_cnt !== 0) begin
      errors++; $display("FAIL reset_errpulse got=%0d exp=0", err_cnt);
    end
  endtask

  task automatic test_decode();
    out_t got;
    int p0, e0;
    logic [7:0] w;
    w = 8'($urandom);
    p0 = pv_cnt; e0 = err_cnt;
    send_packet(8'h09, 8'h05, 8'hFB, w);
    cur_exp = model(8'h09, 8'h05, 8'hFB, w);
    got = get_out();
    checks++;
    if (got !== cur_exp) begin
      errors++; $display("FAIL pkt_09_05_fb got=%h exp=%h", got, cur_exp);
    end
    checks++;
    if ({got.click, got.der, got.mag_x} !== {1'b1, 1'b1, 8'd5}) begin
      errors++; $display("FAIL pkt_09_click_x got=%b%b/%0d exp=11/5", got.click, got.der, got.mag_x);
    end
    checks++;
    if (pv_cnt - p0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL pkt_09_pulses got pv=%0d err=%0d exp pv=1 err=0", pv_cnt - p0, err_cnt - e0);
    end

    send_packet(8'h29, 8'h05, 8'hFB, w);
    cur_exp = model(8'h29, 8'h05, 8'hFB, w);
    got = get_out();
    checks++;
    if ({got.aba, got.arr, got.mag_y, got.der, got.mag_x} !== {1'b1, 1'b0, 8'd5, 1'b1, 8'd5}) begin
      errors++; $display("FAIL pkt_29_y_down got=%h exp aba=1 magy=5 der=1 magx=5", got);
    end

    p0 = pv_cnt;
    send_packet(8'h38, 8'h00, 8'h00, w);
    cur_exp = model(8'h38, 8'h00, 8'h00, w);
    got = get_out();
    checks++;
    if ({got.izq, got.der, got.aba, got.arr, got.mag_x, got.mag_y} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 8'd255, 8'd255}) begin
      errors++; $display("FAIL pkt_38_saturate got=%h exp izq=1 aba=1 mag=255/255", got);
    end
    checks++;
    if (pv_cnt - p0 !== 1) begin
      errors++; $display("FAIL pkt_38_pulse got=%0d exp=1", pv_cnt - p0);
    end
  endtask

  task automatic test_parity_error();
    out_t got, nxt;
    int p0, e0;
    p0 = pv_cnt; e0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0, 11);
    send_frame(8'h10, 1'b1, 1'b0, 11);
    got = get_out();
    checks++;
    if (err_cnt - e0 !== 1 || pv_cnt - p0 !== 0) begin
      errors++; $display("FAIL parity_pulses got err=%0d pv=%0d exp err=1 pv=0", err_cnt - e0, pv_cnt - p0);
    end
    checks++;
    if (got !== cur_exp) begin
      errors++; $display("FAIL parity_hold got=%h exp=%h", got, cur_exp);
    end
    send_packet(8'h08, 8'h10, 8'h20, 8'h03);
    nxt = model(8'h08, 8'h10, 8'h20, 8'h03);
    cur_exp = nxt;
    got = get_out();
    checks++;
    if (got !== cur_exp || pv_cnt - p0 !== 1) begin
      errors++; $display("FAIL parity_recover got=%h pv=%0d exp=%h pv=1", got, pv_cnt - p0, cur_exp);
    end
  endtask

  task automatic test_resync();
    out_t got;
    int p0, e0;
    p0 = pv_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 11);
    send_packet(8'h08, 8'h01, 8'h01, 8'h0F);
    cur_exp = model(8'h08, 8'h01, 8'h01, 8'h0F);
    got = get_out();
    checks++;
    if (err_cnt - e0 !== 1 || pv_cnt - p0 !== 1) begin
      errors++; $display("FAIL resync_pulses got err=%0d pv=%0d exp err=1 pv=1", err_cnt - e0, pv_cnt - p0);
    end
    checks++;
    if ({got.der, got.arr, got.izq, got.aba, got.mag_x, got.mag_y} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1} || got !== cur_exp) begin
      errors++; $display("FAIL resync_decode got=%h exp=%h", got, cur_exp);
    end
  endtask

  task automatic test_bad_stop();
    out_t got;
    int p0, e0;
    p0 = pv_cnt; e0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0, 11);
    send_frame(8'h03, 1'b0, 1'b1, 11);
    send_frame(8'h03, 1'b0, 1'b0, 11);
    send_frame(8'hFC, 1'b0, 1'b0, 11);
    if (NB == 4) send_frame(8'h09, 1'b0, 1'b0, 11);
    cur_exp = model(8'h08, 8'h03, 8'hFC, 8'h09);
    got = get_out();
    checks++;
    if (err_cnt - e0 !== 1 || pv_cnt - p0 !== 1) begin
      errors++; $display("FAIL stop_pulses got err=%0d pv=%0d exp err=1 pv=1", err_cnt - e0, pv_cnt - p0);
    end
    checks++;
    if (got !== cur_exp) begin
      errors++; $display("FAIL stop_decode got=%h exp=%h", got, cur_exp);
    end
  endtask

  task automatic test_timeout();
    out_t got;
    int p0, e0;
    p0 = pv_cnt; e0 = err_cnt;
    send_frame(8'h08, 1'b0, 1'b0, 11);
    send_frame(8'h02, 1'b0, 1'b0, 11);
    repeat (TIMEOUT_CYC + 1) @(negedge Clk);
    got = get_out();
    checks++;
    if (err_cnt - e0 !== 1 || pv_cnt - p0 !== 0) begin
      errors++; $display("FAIL timeout_pulses got err=%0d pv=%0d exp err=1 pv=0", err_cnt - e0, pv_cnt - p0);
    end
    checks++;
    if (got !== cur_exp) begin
      errors++; $display("FAIL timeout_hold got=%h exp=%h", got, cur_exp);
    end
    send_packet(8'h1B, 8'hF0, 8'h44, 8'h0A);
    cur_exp = model(8'h1B, 8'hF0, 8'h44, 8'h0A);
    got = get_out();
    checks++;
    if (got !== cur_exp || pv_cnt - p0 !== 1) begin
      errors++; $display("FAIL timeout_recover got=%h pv=%0d exp=%h pv=1", got, pv_cnt - p0, cur_exp);
    end
  endtask

  task automatic test_midframe_reset();
    out_t got;
    int p0, e0;
    send_frame(8'h08, 1'b0, 1'b0, 5);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    cur_exp = '0;
    got = get_out();
    checks++;
    if (got !== cur_exp) begin
      errors++; $display("FAIL midreset_outputs got=%h exp=%h", got, cur_exp);
    end
    p0 = pv_cnt; e0 = err_cnt;
    send_packet(8'h0C, 8'h7F, 8'h80, 8'h05);
    cur_exp = model(8'h0C, 8'h7F, 8'h80, 8'h05);
    got = get_out();
    checks++;
    if (got !== cur_exp || pv_cnt - p0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL midreset_recover got=%h pv=%0d err=%0d exp=%h pv=1 err=0",
                         got, pv_cnt - p0, err_cnt - e0, cur_exp);
    end
  endtask

  task automatic test_back_to_back();
    out_t got;
    int p0;
    logic [7:0] b0, b1, b2, b3;
    for (int n = 0; n < 18; n++) begin
      b0 = 8'($urandom) | 8'h08;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      p0 = pv_cnt;
      send_packet(b0, b1, b2, b3);
      cur_exp = model(b0, b1, b2, b3);
      got = get_out();
      checks++;
      if (got !== cur_exp || pv_cnt - p0 !== 1) begin
        errors++; $display("FAIL random_pkt%0d bytes=%h %h %h %h got=%h pv=%0d exp=%h pv=1",
                           n, b0, b1, b2, b3, got, pv_cnt - p0, cur_exp);
      end
    end
  endtask

  initial begin
    bus.M_CLK = 1'b1;
    bus.M_Dat = 1'b1;
    test_reset();
    test_decode();
    test_parity_error();
    test_resync();
    test_bad_stop();
    test_timeout();
    test_midframe_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
